// File: rtl/i2s_sample_fifo.sv
// Circular-buffer sample FIFO for an I2S receiver path: first-word fall-through, sticky overflow/underflow flags.
// Optional occupancy outputs (level, max_level) are enabled by defining I2S_SAMPLE_FIFO_LEVEL_EN.
module i2s_sample_fifo #(
    parameter int data_width = 24,
    parameter int depth_log2 = 3
) (
    input  logic                         bclk,
    input  logic                         rst,
    input  logic signed [data_width-1:0] in_sample,
    input  logic                         in_valid,
    output logic signed [data_width-1:0] out_sample,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         clear_flags,
    output logic                         overflow,
    output logic                         underflow
`ifdef I2S_SAMPLE_FIFO_LEVEL_EN
    ,
    output logic [depth_log2:0]          level,
    output logic [depth_log2:0]          max_level
`endif
);

    localparam int depth = 2 ** depth_log2;
    localparam logic [depth_log2:0] full_count = {1'b1, {depth_log2{1'b0}}};

    logic signed [data_width-1:0] mem_q [depth];
    logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d;
    logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d;
    logic [depth_log2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_en, wr_en;

    always_comb begin
        rd_en       = (count_q != '0) && out_ready;
        // A full FIFO still accepts a write when a read frees the head slot in the same cycle.
        wr_en       = in_valid && ((count_q != full_count) || rd_en);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set events OR in after the clear term so a same-cycle event wins over clear_flags.
        overflow_d  = (in_valid && (count_q == full_count) && !rd_en) || (overflow_q && !clear_flags);
        underflow_d = (out_ready && (count_q == '0)) || (underflow_q && !clear_flags);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge bclk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage has no reset; an entry is only visible once count covers it, so stale contents are harmless.
    always_ff @(posedge bclk) begin
        if (rst && wr_en) mem_q[wr_ptr_q] <= in_sample;
    end

    assign out_sample = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

`ifdef I2S_SAMPLE_FIFO_LEVEL_EN
    logic [depth_log2:0] max_level_q, max_level_d;

    // Clearing restarts the high-water mark from the occupancy reached on the same edge.
    always_comb begin
        max_level_d = max_level_q;
        if (clear_flags || (count_d > max_level_q)) max_level_d = count_d;
    end

    always_ff @(posedge bclk) begin
        if (!rst) max_level_q <= '0;
        else      max_level_q <= max_level_d;
    end

    assign level     = count_q;
    assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Self-checking bench for i2s_sample_fifo: directed scenarios then randomized traffic against a queue model.
// Define I2S_SAMPLE_FIFO_LEVEL_EN for both files to also cover level/max_level.
module tb_i2s_sample_fifo;

    localparam int W     = 24;
    localparam int DLOG2 = 3;
    localparam int DEPTH = 8;

    logic                bclk;
    logic                rst;
    logic signed [W-1:0] in_sample;
    logic                in_valid;
    logic signed [W-1:0] out_sample;
    logic                out_valid;
    logic                out_ready;
    logic                clear_flags;
    logic                overflow;
    logic                underflow;
`ifdef I2S_SAMPLE_FIFO_LEVEL_EN
    logic [DLOG2:0]      level;
    logic [DLOG2:0]      max_level;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: a plain queue of accepted samples plus the flag and high-water values.
    logic [W-1:0] mq[$];
    logic         m_ovf;
    logic         m_unf;
    int           m_max;

    i2s_sample_fifo #(.data_width(W), .depth_log2(DLOG2)) dut (
        .bclk        (bclk),
        .rst         (rst),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .out_sample  (out_sample),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .clear_flags (clear_flags),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef I2S_SAMPLE_FIFO_LEVEL_EN
        ,
        .level       (level),
        .max_level   (max_level)
`endif
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("underflow", {31'd0, underflow}, {31'd0, m_unf});
        if (mq.size() != 0) check("out_sample", {8'd0, out_sample}, {8'd0, mq[0]});
`ifdef I2S_SAMPLE_FIFO_LEVEL_EN
        check("level", {28'd0, level}, mq.size());
        check("max_level", {28'd0, max_level}, m_max);
`endif
    endtask

    // Advance one bclk edge: update the model from the inputs currently driven, then compare.
    task automatic tick();
        int  n;
        bit  rd;
        bit  wr;
        n = mq.size();
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_max = 0;
        end else begin
            rd    = out_ready && (n > 0);
            wr    = in_valid && ((n < DEPTH) || rd);
            m_ovf = (in_valid && (n == DEPTH) && !rd) || (m_ovf && !clear_flags);
            m_unf = (out_ready && (n == 0)) || (m_unf && !clear_flags);
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back(in_sample);
            if (clear_flags || (mq.size() > m_max)) m_max = mq.size();
        end
        @(posedge bclk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [W-1:0] s, input logic r, input logic c);
        in_valid    = v;
        in_sample   = s;
        out_ready   = r;
        clear_flags = c;
    endtask

    initial begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_max = 0;
        rst   = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // Fill to depth 8 with out_ready low; first write is visible one cycle later
        rst = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0);
            tick();
            if (i == 1) check("first_write_latency", {31'd0, out_valid}, 32'd1);
        end
        check("full_no_ovf", {31'd0, overflow}, 32'd0);

        // Write into full FIFO: dropped, overflow set
        drive(1'b1, 24'h7FFFFF, 1'b0, 1'b0);
        tick();
        check("full_drop_ovf", {31'd0, overflow}, 32'd1);
        check("full_head_kept", {8'd0, out_sample}, 32'h000001);

        // Clear flags, then simultaneous read/write on a full FIFO
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        drive(1'b1, 24'h800000, 1'b1, 1'b0);
        tick();
        check("full_rw_no_ovf", {31'd0, overflow}, 32'd0);
        check("full_rw_head", {8'd0, out_sample}, 32'h000002);

        // Drain: 2..8, then 0x800000 ninth
        for (int i = 2; i <= DEPTH + 1; i++) begin
            check("drain_order", {8'd0, out_sample}, (i <= DEPTH) ? i : 32'h800000);
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
        end
        check("drained_empty", {31'd0, out_valid}, 32'd0);

        // Underflow on empty for 3 cycles; clear with simultaneous underflow keeps it set
        for (int i = 0; i < 2; i++) tick();
        check("unf_set", {31'd0, underflow}, 32'd1);
        drive(1'b0, '0, 1'b1, 1'b1);
        tick();
        check("unf_set_wins", {31'd0, underflow}, 32'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("unf_cleared", {31'd0, underflow}, 32'd0);

        // Single-entry simultaneous read/write keeps one entry
        drive(1'b1, 24'h0ABCDE, 1'b0, 1'b0);
        tick();
        drive(1'b1, 24'h054321, 1'b1, 1'b0);
        tick();
        check("one_entry_rw", {8'd0, out_sample}, 32'h054321);

        // Write 5 more, reset mid-operation with strobes active
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 24'h0F0F0F, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_unf", {31'd0, underflow}, 32'd0);
        rst = 1'b1;
        drive(1'b1, 24'h123456, 1'b0, 1'b0);
        tick();
        check("post_rst_first", {8'd0, out_sample}, 32'h123456);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

`ifdef I2S_SAMPLE_FIFO_LEVEL_EN
        // Level: write 6 then read 4 -> level 2, max 6; clear -> max 2
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, W'(32'h200 + i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
        end
        check("lvl_level", {28'd0, level}, 32'd2);
        check("lvl_max", {28'd0, max_level}, 32'd6);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("lvl_max_cleared", {28'd0, max_level}, 32'd2);
`endif

        // Randomized traffic, alternating write-heavy and read-heavy phases to hit full and empty
        for (int i = 0; i < 600; i++) begin
            bit heavy_wr;
            heavy_wr    = ((i / 40) % 2) == 0;
            in_valid    = ($urandom % 4) < (heavy_wr ? 3 : 1);
            out_ready   = ($urandom % 4) < (heavy_wr ? 1 : 3);
            in_sample   = W'($urandom);
            clear_flags = ($urandom % 16) == 0;
            rst         = ($urandom % 150) != 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_sample_fifo.md
I2S_SAMPLE_FIFO -- requirements
Module: i2s_sample_fifo

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset.
REQ-002 Parameter data_width, default 24: sample width in bits.
REQ-003 Parameter depth_log2, default 3: FIFO depth is 2**depth_log2 entries.
REQ-004 Port bclk, input, 1: sole clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1: synchronous active-low reset, sampled on the bclk rising edge.
REQ-006 Port in_sample, input, signed data_width: receiver sample.
REQ-007 Port in_valid, input, 1: one-cycle strobe; in_sample is valid this cycle.
REQ-008 Port out_sample, output, signed data_width: the sample at the head of the FIFO.
REQ-009 Port out_valid, output, 1: high when the FIFO holds at least one entry.
REQ-010 Port out_ready, input, 1: the consumer accepts the head entry when out_valid and out_ready are both high.
REQ-011 Port clear_flags, input, 1: clears the sticky flags.
REQ-012 Port overflow, output, 1: sticky; a write was dropped.
REQ-013 Port underflow, output, 1: sticky; out_ready was high while out_valid was low.

Function
REQ-014 The storage SHALL be a circular buffer with read/write pointers of depth_log2 bits that wrap from 2**depth_log2-1 to 0, plus an occupancy count of depth_log2+1 bits.
REQ-015 A write SHALL occur when in_valid=1 and either count<depth, or a read occurs in the same cycle.
REQ-016 A read SHALL occur when out_valid=1 and out_ready=1; it advances the read pointer and out_sample presents the next entry in the following cycle.
REQ-017 Latency from a write into an empty FIFO to out_valid=1 SHALL be one cycle; there is no same-cycle bypass.
REQ-018 out_sample SHALL equal the entry at the read pointer (first-word fall-through); its value while out_valid=0 is don't-care.
REQ-019 Simultaneous read and write SHALL leave count unchanged, including when the FIFO is full or holds exactly one entry.
REQ-020 When in_valid=1, count=depth and no read occurs: the new sample SHALL be dropped, stored data SHALL be unchanged, and overflow SHALL be set on the next edge.
REQ-021 When out_ready=1 and out_valid=0: state SHALL be unchanged and underflow SHALL be set on the next edge.
REQ-022 When clear_flags=1: both flags SHALL clear on the next edge; a set event in the same cycle SHALL win over the clear.
REQ-023 Samples SHALL be delivered in write order, bit-exact, with no sign or width change.

Reset
REQ-024 With rst=0 at a bclk edge: pointers, count, overflow and underflow SHALL be 0; out_valid SHALL be 0; memory contents need not be cleared.
REQ-025 Reset mid-operation SHALL discard all stored samples; in_valid and out_ready SHALL be ignored during the reset cycle.
REQ-026 The first write SHALL be accepted on the first edge with rst=1.

Configuration
REQ-027 With macro I2S_SAMPLE_FIFO_LEVEL_EN defined: the block SHALL add output level (depth_log2+1 bits, equal to count) and output max_level (same width, high-water mark of count).
REQ-028 max_level SHALL reset to 0 and be cleared by clear_flags, with the same set-wins priority as the flags.
REQ-029 Without I2S_SAMPLE_FIFO_LEVEL_EN: the level and max_level ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Depth 8, out_ready=0, write 0x000001..0x000008 -> out_valid=1 one cycle after the first write, count 8, overflow=0.
REQ-031 From full, write 0x7FFFFF with out_ready=0 -> overflow=1, then reads return 0x000001..0x000008 only.
REQ-032 From full, in_valid=1 and out_ready=1 in the same cycle with 0x800000 -> count stays 8, 0x800000 is read ninth.
REQ-033 Empty FIFO, out_ready=1 for 3 cycles -> underflow=1, out_valid=0; clear_flags with a simultaneous underflow -> underflow stays 1.
REQ-034 Write 5 samples, assert rst=0 for one cycle -> out_valid=0, flags 0; a new write of 0x123456 is read back as the first entry.
REQ-035 Build with I2S_SAMPLE_FIFO_LEVEL_EN, write 6 then read 4 -> level=2, max_level=6; clear_flags -> max_level=2.
